// File: rtl/systolic_pkg.sv
// Shared defaults, frame sizing and FSM state encoding for the systolic operand loader.
package systolic_pkg;

    localparam int unsigned DEF_DW      = 8;
    localparam int unsigned DEF_ROWS    = 4;
    localparam int unsigned DEF_COLS    = 4;
    localparam int unsigned DEF_K       = 4;
    localparam int unsigned DEF_CLK_DIV = 2;

    localparam int unsigned DEF_NA  = DEF_ROWS * DEF_K;
    localparam int unsigned DEF_NB  = DEF_K * DEF_COLS;
    localparam int unsigned DEF_A_W = DEF_NA * DEF_DW;
    localparam int unsigned DEF_B_W = DEF_NB * DEF_DW;

    typedef enum logic [1:0] {
        LOAD_A    = 2'd0,
        LOAD_B    = 2'd1,
        SEND      = 2'd2,
        WAIT_DONE = 2'd3
    } state_e;

    // Counter width able to index 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? 32'($clog2(n)) : 32'd1;
    endfunction

endpackage

// File: rtl/systolic_operand_loader_if.sv
// Element stream (valid/ready) carrying A then B matrix elements into the loader.
interface systolic_operand_loader_if #(
    parameter int unsigned DW = systolic_pkg::DEF_DW
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_last;

    modport master (output in_valid, output in_data, output in_last, input in_ready);
    modport slave  (input in_valid, input in_data, input in_last, output in_ready);
endinterface

// File: rtl/serial_frame_tx.sv
// One serial link: shifts a frame out MSB first with a divided bit clock and a frame envelope.
module serial_frame_tx
    import systolic_pkg::*;
#(
    parameter int unsigned W       = DEF_A_W,
    parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] frame,
    output logic         serial_data,
    output logic         serial_clk,
    output logic         frame_sync,
    output logic         done_c
);

    localparam int unsigned PHASES = 2 * CLK_DIV;
    localparam int unsigned PW     = cnt_width(PHASES);
    localparam int unsigned BW     = cnt_width(W);

    logic          active;
    logic [PW-1:0] phase;
    logic [BW-1:0] bit_cnt;
    logic [W-2:0]  shreg;
    logic          bit_end_c;

    assign bit_end_c = active && (phase == PW'(PHASES - 1));
    assign done_c    = bit_end_c && (bit_cnt == BW'(W - 1));

    // Data and sync only change at a bit boundary, i.e. the start of the low phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            active      <= 1'b0;
            phase       <= '0;
            bit_cnt     <= '0;
            serial_data <= 1'b0;
            serial_clk  <= 1'b0;
            frame_sync  <= 1'b0;
        end else if (start) begin
            active      <= 1'b1;
            phase       <= '0;
            bit_cnt     <= '0;
            serial_data <= frame[W-1];
            serial_clk  <= 1'b0;
            frame_sync  <= 1'b1;
        end else if (done_c) begin
            active      <= 1'b0;
            phase       <= '0;
            bit_cnt     <= '0;
            serial_data <= 1'b0;
            serial_clk  <= 1'b0;
            frame_sync  <= 1'b0;
        end else if (bit_end_c) begin
            phase       <= '0;
            bit_cnt     <= bit_cnt + BW'(1);
            serial_data <= shreg[W-2];
            serial_clk  <= 1'b0;
        end else if (active) begin
            phase       <= phase + PW'(1);
            serial_clk  <= (phase + PW'(1)) >= PW'(CLK_DIV);
        end
    end

    // Remaining bits queue up behind the one currently on the wire.
    always_ff @(posedge clk) begin
        if (start) begin
            shreg <= frame[W-2:0];
        end else if (bit_end_c) begin
            shreg <= {shreg[W-3:0], 1'b0};
        end
    end

endmodule

// File: rtl/systolic_operand_loader.sv
// Buffers A and B operand frames from an element stream, ships both over serial links,
// then requests a core start and waits for done.
module systolic_operand_loader
    import systolic_pkg::*;
#(
    parameter int unsigned DW      = DEF_DW,
    parameter int unsigned ROWS    = DEF_ROWS,
    parameter int unsigned COLS    = DEF_COLS,
    parameter int unsigned K       = DEF_K,
    parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
    input  logic                        clk,
    input  logic                        rst,
    systolic_operand_loader_if.slave    elem,
    output logic                        A_serial_data,
    output logic                        A_serial_clk,
    output logic                        A_frame_sync,
    output logic                        B_serial_data,
    output logic                        B_serial_clk,
    output logic                        B_frame_sync,
    output logic                        core_start,
    input  logic                        core_done,
    output logic                        busy,
    output logic                        err_last
);

    localparam int unsigned NA  = ROWS * K;
    localparam int unsigned NB  = K * COLS;
    localparam int unsigned A_W = NA * DW;
    localparam int unsigned B_W = NB * DW;
    localparam int unsigned ACW = cnt_width(NA);
    localparam int unsigned BCW = cnt_width(NB);

    state_e         state, state_d;
    logic [ACW-1:0] a_cnt, a_cnt_d;
    logic [BCW-1:0] b_cnt, b_cnt_d;
    logic [A_W-1:0] abuf, abuf_d;
    logic [B_W-1:0] bbuf, bbuf_d;
    logic           in_ready_q;
    logic           err_d;
    logic           accept_c;
    logic           start_c;
    logic           a_done_c;
    logic           b_done_c;
    logic           send_done_c;

    assign accept_c      = elem.in_valid & in_ready_q;
    assign elem.in_ready = in_ready_q;
    // The longer link finishes last and closes the SEND window.
    assign send_done_c   = (NA >= NB) ? a_done_c : b_done_c;

    // Next-state, load counters, buffer writes and in_last checking.
    always_comb begin
        state_d = state;
        a_cnt_d = a_cnt;
        b_cnt_d = b_cnt;
        abuf_d  = abuf;
        bbuf_d  = bbuf;
        err_d   = err_last;
        start_c = 1'b0;
        unique case (state)
            LOAD_A: begin
                if (accept_c) begin
                    abuf_d[32'(a_cnt) * DW +: DW] = elem.in_data;
                    if (elem.in_last) begin
                        err_d = 1'b1;
                    end
                    if (a_cnt == ACW'(NA - 1)) begin
                        a_cnt_d = '0;
                        state_d = LOAD_B;
                    end else begin
                        a_cnt_d = a_cnt + ACW'(1);
                    end
                end
            end
            LOAD_B: begin
                if (accept_c) begin
                    bbuf_d[32'(b_cnt) * DW +: DW] = elem.in_data;
                    if (elem.in_last != (b_cnt == BCW'(NB - 1))) begin
                        err_d = 1'b1;
                    end
                    if (b_cnt == BCW'(NB - 1)) begin
                        b_cnt_d = '0;
                        state_d = SEND;
                        start_c = 1'b1;
                    end else begin
                        b_cnt_d = b_cnt + BCW'(1);
                    end
                end
            end
            SEND: begin
                if (send_done_c) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (core_done) begin
                    state_d = LOAD_A;
                end
            end
            default: begin
                state_d = LOAD_A;
            end
        endcase
    end

    // State and registered status outputs, all derived from next-state values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= LOAD_A;
            a_cnt      <= '0;
            b_cnt      <= '0;
            in_ready_q <= 1'b1;
            core_start <= 1'b0;
            busy       <= 1'b0;
            err_last   <= 1'b0;
        end else begin
            state      <= state_d;
            a_cnt      <= a_cnt_d;
            b_cnt      <= b_cnt_d;
            in_ready_q <= (state_d == LOAD_A) || (state_d == LOAD_B);
            core_start <= (state_d == WAIT_DONE);
            busy       <= !((state_d == LOAD_A) && (a_cnt_d == '0));
            err_last   <= err_d;
        end
    end

    // Operand buffers carry no reset; an abandoned frame is simply overwritten.
    always_ff @(posedge clk) begin
        abuf <= abuf_d;
        bbuf <= bbuf_d;
    end

    // B frame taps the next-value buffer so the final element, accepted on the start edge, is included.
    serial_frame_tx #(
        .W       (A_W),
        .CLK_DIV (CLK_DIV)
    ) u_a_tx (
        .clk         (clk),
        .rst         (rst),
        .start       (start_c),
        .frame       (abuf_d),
        .serial_data (A_serial_data),
        .serial_clk  (A_serial_clk),
        .frame_sync  (A_frame_sync),
        .done_c      (a_done_c)
    );

    serial_frame_tx #(
        .W       (B_W),
        .CLK_DIV (CLK_DIV)
    ) u_b_tx (
        .clk         (clk),
        .rst         (rst),
        .start       (start_c),
        .frame       (bbuf_d),
        .serial_data (B_serial_data),
        .serial_clk  (B_serial_clk),
        .frame_sync  (B_frame_sync),
        .done_c      (b_done_c)
    );

endmodule

// File: tb/tb_systolic_operand_loader.sv
// Scoreboard bench: expected serial frames are queued at load time and matched by a link monitor.
module tb_systolic_operand_loader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       in_valid  = 1'b0;
    logic       in_last   = 1'b0;
    logic [7:0] in_data   = 8'd0;
    logic       core_done = 1'b0;
    int         sel       = 0;

    systolic_operand_loader_if #(.DW(8)) bus0 ();
    systolic_operand_loader_if #(.DW(8)) bus1 ();

    logic sd [4];
    logic sc [4];
    logic fs [4];
    logic cs_v [2];
    logic busy_v [2];
    logic err_v [2];
    logic cd_v [2];
    logic rdy;

    assign bus0.in_valid = in_valid && (sel == 0);
    assign bus0.in_data  = in_data;
    assign bus0.in_last  = in_last;
    assign bus1.in_valid = in_valid && (sel == 1);
    assign bus1.in_data  = in_data;
    assign bus1.in_last  = in_last;
    assign cd_v[0]       = core_done && (sel == 0);
    assign cd_v[1]       = core_done && (sel == 1);
    assign rdy           = (sel == 1) ? bus1.in_ready : bus0.in_ready;

    systolic_operand_loader dut0 (
        .clk (clk), .rst (rst), .elem (bus0),
        .A_serial_data (sd[0]), .A_serial_clk (sc[0]), .A_frame_sync (fs[0]),
        .B_serial_data (sd[1]), .B_serial_clk (sc[1]), .B_frame_sync (fs[1]),
        .core_start (cs_v[0]), .core_done (cd_v[0]), .busy (busy_v[0]), .err_last (err_v[0])
    );

    systolic_operand_loader #(.K(3), .CLK_DIV(1)) dut1 (
        .clk (clk), .rst (rst), .elem (bus1),
        .A_serial_data (sd[2]), .A_serial_clk (sc[2]), .A_frame_sync (fs[2]),
        .B_serial_data (sd[3]), .B_serial_clk (sc[3]), .B_frame_sync (fs[3]),
        .core_start (cs_v[1]), .core_done (cd_v[1]), .busy (busy_v[1]), .err_last (err_v[1])
    );

    localparam int LW  [4] = '{128, 128, 96, 96};
    localparam int LCD [4] = '{2, 2, 1, 1};

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    // Scoreboard: per-link ring of expected frames.
    logic [127:0] exp_mem [4][8];
    int           wr_ptr [4] = '{0, 0, 0, 0};
    int           rd_ptr [4] = '{0, 0, 0, 0};
    logic [7:0]   stream [32];
    logic         exp_err = 1'b0;

    // Reference model: element i of a frame occupies bits [i*8 +: 8].
    function automatic logic [127:0] pack_frame(input int off, input int n);
        logic [127:0] f;
        f = '0;
        for (int i = 0; i < n; i++) f[i*8 +: 8] = stream[off + i];
        return f;
    endfunction

    task automatic push_exp(input int link, input logic [127:0] f);
        exp_mem[link][wr_ptr[link] % 8] = f;
        wr_ptr[link]++;
    endtask

    // Link monitor: captures bits on serial_clk rising edges inside the frame_sync envelope.
    int           cyc = 0;
    logic         inf [4]        = '{1'b0, 1'b0, 1'b0, 1'b0};
    logic         psc [4]        = '{1'b0, 1'b0, 1'b0, 1'b0};
    logic         per_ok [4]     = '{1'b1, 1'b1, 1'b1, 1'b1};
    logic [127:0] cap [4];
    logic [127:0] last_frame [4];
    int           nb [4]         = '{0, 0, 0, 0};
    int           slen [4]       = '{0, 0, 0, 0};
    int           last_rise [4]  = '{0, 0, 0, 0};

    always @(negedge clk) begin
        cyc++;
        for (int i = 0; i < 4; i++) begin
            if (rst) begin
                inf[i] = 1'b0;
            end else if (fs[i]) begin
                if (!inf[i]) begin
                    inf[i] = 1'b1; cap[i] = '0; nb[i] = 0; slen[i] = 0; per_ok[i] = 1'b1;
                end
                slen[i]++;
                if (sc[i] && !psc[i]) begin
                    if (nb[i] > 0 && (cyc - last_rise[i]) != 2 * LCD[i]) per_ok[i] = 1'b0;
                    last_rise[i] = cyc;
                    cap[i] = {cap[i][126:0], sd[i]};
                    nb[i]++;
                end
            end else if (inf[i]) begin
                inf[i] = 1'b0;
                last_frame[i] = cap[i];
                chk($sformatf("bit_count link%0d", i), 128'(nb[i]), 128'(LW[i]));
                chk($sformatf("sync_width link%0d", i), 128'(slen[i]), 128'(LW[i] * 2 * LCD[i]));
                chk($sformatf("bit_period link%0d", i), 128'(per_ok[i]), 128'(1));
                if (rd_ptr[i] == wr_ptr[i]) begin
                    chk($sformatf("unexpected_frame link%0d", i), 128'(1), 128'(0));
                end else begin
                    chk($sformatf("frame link%0d", i), cap[i], exp_mem[i][rd_ptr[i] % 8]);
                    rd_ptr[i]++;
                end
            end
            psc[i] = sc[i];
        end
    end

    // Stream one A+B frame, then run the core handshake (done_delay<0: done already high).
    task automatic run_frame(input int n_a, input int n_b, input int prob, input int last_idx,
                             input int done_delay, input bit abort);
        int tot;
        int idx;
        int guard;
        int n;
        int wmax;
        bit v;
        bit ok;
        tot   = n_a + n_b;
        idx   = 0;
        guard = 0;
        wmax  = (n_a > n_b ? n_a : n_b) * 8 * ((sel == 1) ? 2 : 4);
        if (!abort) begin
            push_exp(2 * sel, pack_frame(0, n_a));
            push_exp(2 * sel + 1, pack_frame(n_a, n_b));
        end
        if (last_idx != tot - 1) exp_err = 1'b1;
        while (idx < tot && guard < 4000) begin
            @(negedge clk);
            guard++;
            v        = int'($urandom_range(99)) < prob;
            in_valid = v;
            in_data  = stream[idx];
            in_last  = (idx == last_idx);
            if (v && rdy) idx++;
        end
        chk("load_count", 128'(idx), 128'(tot));
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("ready_low_in_send", 128'(rdy), 128'(0));
        chk("busy_in_send", 128'(busy_v[sel]), 128'(1));
        if (abort) begin
            repeat (39) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            chk("abort_links_zero",
                128'({sd[2*sel], sc[2*sel], fs[2*sel], sd[2*sel+1], sc[2*sel+1], fs[2*sel+1]}),
                128'(0));
            chk("abort_ready", 128'(rdy), 128'(1));
            chk("abort_busy", 128'(busy_v[sel]), 128'(0));
            chk("abort_start", 128'(cs_v[sel]), 128'(0));
            @(negedge clk);
            rst     = 1'b0;
            exp_err = 1'b0;
            return;
        end
        if (done_delay < 0) core_done = 1'b1;
        n = 1;
        while (!cs_v[sel] && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("send_length", 128'(n), 128'(wmax + 1));
        if (done_delay < 0) begin
            @(negedge clk);
            chk("start_pulse", 128'(cs_v[sel]), 128'(0));
            core_done = 1'b0;
        end else begin
            ok = 1'b1;
            repeat (done_delay) begin
                @(negedge clk);
                if (!cs_v[sel]) ok = 1'b0;
            end
            chk("start_held", 128'(ok), 128'(1));
            core_done = 1'b1;
            @(negedge clk);
            core_done = 1'b0;
            chk("start_drop", 128'(cs_v[sel]), 128'(0));
        end
        chk("ready_after_done", 128'(rdy), 128'(1));
        chk("busy_idle", 128'(busy_v[sel]), 128'(0));
        chk("err_last", 128'(err_v[sel]), 128'(exp_err));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) stream[i] = 8'(i + 1);
        repeat (3) @(negedge clk);
        chk("reset_state dut0",
            128'({bus0.in_ready, cs_v[0], busy_v[0], err_v[0], sd[0], sc[0], fs[0], sd[1], sc[1], fs[1]}),
            128'(10'b10_0000_0000));
        chk("reset_state dut1",
            128'({bus1.in_ready, cs_v[1], busy_v[1], err_v[1], sd[2], sc[2], fs[2], sd[3], sc[3], fs[3]}),
            128'(10'b10_0000_0000));
        rst = 1'b0;
        sel = 0;

        run_frame(16, 16, 100, 31, 3, 1'b0);
        repeat (2) @(negedge clk);
        chk("a_frame_low_byte", 128'(last_frame[0][7:0]), 128'(8'h01));
        chk("b_frame_high_byte", 128'(last_frame[1][127:120]), 128'(8'h20));

        run_frame(16, 16, 100, 31, 10, 1'b0);
        run_frame(16, 16, 50, 31, 4, 1'b0);

        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 32; i++) stream[i] = 8'($urandom);
            run_frame(16, 16, 70, 31, int'($urandom_range(0, 5)), 1'b0);
        end

        run_frame(16, 16, 100, 5, 2, 1'b0);
        run_frame(16, 16, 100, 31, -1, 1'b0);
        run_frame(16, 16, 100, 31, 2, 1'b1);
        for (int i = 0; i < 32; i++) stream[i] = 8'($urandom);
        run_frame(16, 16, 80, 31, 1, 1'b0);

        sel = 1;
        for (int i = 0; i < 32; i++) stream[i] = 8'($urandom);
        run_frame(12, 12, 100, 23, 2, 1'b0);
        for (int i = 0; i < 32; i++) stream[i] = 8'($urandom);
        run_frame(12, 12, 60, 23, -1, 1'b0);

        repeat (4) @(negedge clk);
        for (int i = 0; i < 4; i++)
            chk($sformatf("frames_drained link%0d", i), 128'(rd_ptr[i]), 128'(wr_ptr[i]));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
